// File: rtl/management_rx_frame_buffer_pkg.sv
// management_rx_frame_buffer_pkg: shared lengths, header type and frame-state enum for the rx buffer
package management_rx_frame_buffer_pkg;
  localparam int RX_LEN_WIDTH = 11;
  localparam int RX_MAX_BYTES = 2047;
  typedef logic [RX_LEN_WIDTH-1:0] rx_len_t;
  typedef enum logic {IDLE, ACTIVE} rx_state_t;
endpackage

// File: rtl/sync_fwft_fifo.sv
// sync_fwft_fifo: single-clock first-word-fall-through fifo, push ignored when full, pop ignored when empty
module sync_fwft_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign rd_data = empty ? '0 : mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(wr_en && !full);
      rp <= rp + (AW+1)'(rd_en && !empty);
    end
  always_ff @(posedge clk)
    if (wr_en && !full) mem[wp[AW-1:0]] <= wr_data;
endmodule

// File: rtl/management_rx_frame_buffer.sv
// management_rx_frame_buffer: rx word fifo with commit/rewind per frame and a fwft length-header fifo
module management_rx_frame_buffer
  import management_rx_frame_buffer_pkg::*;
#(
  parameter int DATA_DEPTH   = 1024,
  parameter int HEADER_DEPTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx_start,
  input  logic          rx_data_valid,
  input  logic [31:0]   rx_data,
  input  logic [2:0]    rx_bytes_valid,
  input  logic          rx_commit,
  input  logic          rx_drop,
  input  logic          rxfifo_rd_en,
  input  logic          rxfifo_rd_pop_single,
  output logic [31:0]   rxfifo_rd_data,
  input  logic          rxheader_rd_en,
  output logic          rxheader_rd_empty,
  output logic [10:0]   rxheader_rd_data,
  output logic [15:0]   drop_count
);
  localparam int AW = $clog2(DATA_DEPTH);
  logic [31:0] mem [DATA_DEPTH];
  rx_state_t state;
  logic [AW:0] twp, cwp, rptr, twp_b, twp_w;
  logic [11:0] cnt, cnt_b, cnt_n, cnt_w;
  logic bad, partial, bad_b, part_b, bad_n, part_w;
  logic act, restart, full, wr_bad, wr, fin, good, hdr_full, hdr_push, discard;
  rx_len_t hdr_data;
  // a new frame always starts at cwp, which also rewinds a frame interrupted by rx_start
  always_comb begin
    act      = rx_start || state == ACTIVE;
    restart  = rx_start && state == ACTIVE;
    twp_b    = rx_start ? cwp : twp;
    cnt_b    = rx_start ? '0 : cnt;
    bad_b    = rx_start ? 1'b0 : bad;
    part_b   = rx_start ? 1'b0 : partial;
    full     = (twp_b - rptr) == (AW+1)'(DATA_DEPTH);
    cnt_n    = cnt_b + 12'(rx_bytes_valid);
    wr_bad   = act && rx_data_valid && !bad_b && (full || part_b || cnt_n > 12'(RX_MAX_BYTES));
    wr       = act && rx_data_valid && !bad_b && !wr_bad;
    twp_w    = wr ? twp_b + (AW+1)'(1) : twp_b;
    cnt_w    = wr ? cnt_n : cnt_b;
    part_w   = wr ? rx_bytes_valid != 3'd4 : part_b;
    bad_n    = bad_b || wr_bad;
    fin      = act && (rx_commit || rx_drop);
    good     = fin && !rx_drop && !bad_n && cnt_w != '0;
    hdr_push = good && !hdr_full;
    discard  = restart || (fin && (rx_drop || bad_n || (good && hdr_full)));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state          <= IDLE;
      twp            <= '0;
      cwp            <= '0;
      rptr           <= '0;
      cnt            <= '0;
      bad            <= 1'b0;
      partial        <= 1'b0;
      drop_count     <= '0;
      rxfifo_rd_data <= '0;
    end else begin
      if (fin) begin
        state <= IDLE;
        twp   <= hdr_push ? twp_w : cwp;
      end else if (act) begin
        state <= ACTIVE;
        twp   <= twp_w;
      end
      if (hdr_push) cwp <= twp_w;
      cnt     <= cnt_w;
      bad     <= bad_n;
      partial <= part_w;
      if (discard && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      if (rxfifo_rd_en) rxfifo_rd_data <= mem[rptr[AW-1:0]];
      if (rxfifo_rd_pop_single && rptr != cwp) rptr <= rptr + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (wr) mem[twp_b[AW-1:0]] <= rx_data;
  sync_fwft_fifo #(.WIDTH(RX_LEN_WIDTH), .DEPTH(HEADER_DEPTH)) u_hdr (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (hdr_push),
    .wr_data (rx_len_t'(cnt_w[RX_LEN_WIDTH-1:0])),
    .full    (hdr_full),
    .rd_en   (rxheader_rd_en),
    .rd_data (hdr_data),
    .empty   (rxheader_rd_empty)
  );
  assign rxheader_rd_data = hdr_data;
endmodule

// File: tb/tb_management_rx_frame_buffer.sv
// tb_management_rx_frame_buffer: directed frames against hand-computed lengths, words and drop counts
module tb_management_rx_frame_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_start = 1'b0, rx_data_valid = 1'b0, rx_commit = 1'b0, rx_drop = 1'b0;
  logic [31:0] rx_data = '0;
  logic [2:0] rx_bytes_valid = '0;
  logic rxfifo_rd_en = 1'b0, rxfifo_rd_pop_single = 1'b0, rxheader_rd_en = 1'b0;
  logic [31:0] rxfifo_rd_data;
  logic rxheader_rd_empty;
  logic [10:0] rxheader_rd_data;
  logic [15:0] drop_count;
  int nvec = 0, nerr = 0;

  management_rx_frame_buffer #(.DATA_DEPTH(16), .HEADER_DEPTH(2)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .rx_start             (rx_start),
    .rx_data_valid        (rx_data_valid),
    .rx_data              (rx_data),
    .rx_bytes_valid       (rx_bytes_valid),
    .rx_commit            (rx_commit),
    .rx_drop              (rx_drop),
    .rxfifo_rd_en         (rxfifo_rd_en),
    .rxfifo_rd_pop_single (rxfifo_rd_pop_single),
    .rxfifo_rd_data       (rxfifo_rd_data),
    .rxheader_rd_en       (rxheader_rd_en),
    .rxheader_rd_empty    (rxheader_rd_empty),
    .rxheader_rd_data     (rxheader_rd_data),
    .drop_count           (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    rx_start = 1'b1;
    step();
    rx_start = 1'b0;
  endtask

  task automatic word(input logic [31:0] d, input logic [2:0] bv);
    rx_data_valid = 1'b1;
    rx_data = d;
    rx_bytes_valid = bv;
    step();
    rx_data_valid = 1'b0;
  endtask

  task automatic commit();
    rx_commit = 1'b1;
    step();
    rx_commit = 1'b0;
  endtask

  task automatic read_word(input string tag, input logic [31:0] exp);
    rxfifo_rd_en = 1'b1;
    rxfifo_rd_pop_single = 1'b1;
    step();
    rxfifo_rd_en = 1'b0;
    rxfifo_rd_pop_single = 1'b0;
    check(tag, rxfifo_rd_data, exp);
  endtask

  task automatic pop_hdr();
    rxheader_rd_en = 1'b1;
    step();
    rxheader_rd_en = 1'b0;
  endtask

  initial begin
    step();
    check("rst_rd_data", rxfifo_rd_data, 0);
    check("rst_empty", 32'(rxheader_rd_empty), 1);
    check("rst_hdr", 32'(rxheader_rd_data), 0);
    check("rst_drop", 32'(drop_count), 0);
    rst_n = 1'b1;
    step();

    start();
    word(32'h01020304, 3'd4);
    word(32'hAABBCCDD, 3'd4);
    word(32'h11000000, 3'd1);
    check("pre_commit_empty", 32'(rxheader_rd_empty), 1);
    commit();
    check("single_empty", 32'(rxheader_rd_empty), 0);
    check("single_hdr", 32'(rxheader_rd_data), 9);
    read_word("single_w0", 32'h01020304);
    read_word("single_w1", 32'hAABBCCDD);
    read_word("single_w2", 32'h11000000);
    check("single_drop", 32'(drop_count), 0);
    pop_hdr();
    check("single_pop_empty", 32'(rxheader_rd_empty), 1);

    start();
    word(32'hDEAD0001, 3'd4);
    word(32'hDEAD0002, 3'd4);
    word(32'hDEAD0003, 3'd4);
    rx_drop = 1'b1;
    step();
    rx_drop = 1'b0;
    check("macdrop_empty", 32'(rxheader_rd_empty), 1);
    check("macdrop_count", 32'(drop_count), 1);
    start();
    word(32'hCAFEBABE, 3'd4);
    commit();
    check("after_drop_hdr", 32'(rxheader_rd_data), 4);
    read_word("after_drop_w", 32'hCAFEBABE);
    pop_hdr();

    start();
    for (int i = 0; i < 17; i++) word(32'h0000_0500 + 32'(i), 3'd4);
    commit();
    check("ovf_empty", 32'(rxheader_rd_empty), 1);
    check("ovf_count", 32'(drop_count), 2);
    start();
    for (int i = 0; i < 16; i++) word(32'h0000_0100 + 32'(i), 3'd4);
    commit();
    check("full16_empty", 32'(rxheader_rd_empty), 0);
    check("full16_hdr", 32'(rxheader_rd_data), 64);
    for (int i = 0; i < 16; i++) read_word($sformatf("full16_w%0d", i), 32'h0000_0100 + 32'(i));
    check("full16_drop", 32'(drop_count), 2);
    pop_hdr();

    for (int i = 0; i < 3; i++) begin
      start();
      word(32'h0000_0A00 + 32'(i), 3'd4);
      commit();
    end
    check("hdrfull_count", 32'(drop_count), 3);
    check("hdrfull_hdr0", 32'(rxheader_rd_data), 4);
    pop_hdr();
    check("hdrfull_not_empty", 32'(rxheader_rd_empty), 0);
    pop_hdr();
    check("hdrfull_empty", 32'(rxheader_rd_empty), 1);
    read_word("hdrfull_w0", 32'h00000A00);
    read_word("hdrfull_w1", 32'h00000A01);

    start();
    word(32'hA1A1A1A1, 3'd4);
    start();
    word(32'hB2B2B2B2, 3'd4);
    commit();
    check("restart_count", 32'(drop_count), 4);
    check("restart_hdr", 32'(rxheader_rd_data), 4);
    read_word("restart_w", 32'hB2B2B2B2);
    pop_hdr();

    start();
    word(32'hC3C3C3C3, 3'd4);
    rx_commit = 1'b1;
    rx_drop = 1'b1;
    step();
    rx_commit = 1'b0;
    rx_drop = 1'b0;
    check("collide_empty", 32'(rxheader_rd_empty), 1);
    check("collide_count", 32'(drop_count), 5);

    start();
    word(32'h22000000, 3'd1);
    word(32'h33333333, 3'd4);
    commit();
    check("partial_empty", 32'(rxheader_rd_empty), 1);
    check("partial_count", 32'(drop_count), 6);

    start();
    commit();
    check("zero_empty", 32'(rxheader_rd_empty), 1);
    check("zero_count", 32'(drop_count), 6);

    for (int i = 0; i < 2; i++) begin
      start();
      word(32'h0000_0E00 + 32'(i), 3'd4);
      commit();
    end
    check("prereset_empty", 32'(rxheader_rd_empty), 0);
    read_word("prereset_w", 32'h00000E00);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("postrst_empty", 32'(rxheader_rd_empty), 1);
    check("postrst_drop", 32'(drop_count), 0);
    check("postrst_rd_data", rxfifo_rd_data, 0);
    check("postrst_hdr", 32'(rxheader_rd_data), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
